// File: rtl/uart_operand_rx.sv
// uart_operand_rx: UART receiver that turns one host byte into two 4-bit adder operands.
//   The default frame is 8N1. Defining PARITY_EN switches the frame to 8E1, which adds
//   an even parity bit after D7.
//   Each good byte loads a = byte[3:0] and b = byte[7:4] and raises operands_valid for one cycle.
// Ports:
//   clk, rst_n          system clock and asynchronous active-low reset
//   rx                  serial input; idles high and is asynchronous to clk
//   a, b                registered operands taken from the last good byte
//   operands_valid      1-cycle pulse in the cycle a/b update
//   frame_err           1-cycle pulse when the stop bit is sampled low
//   parity_err          1-cycle pulse on a parity mismatch (tied 0 without PARITY_EN)
//   busy                high while the receiver is not idle
`timescale 1ns/1ps
module uart_operand_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       operands_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic             rx_prev_q, rx_prev_d;
  logic [1:0]       sync_vld_q, sync_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;
  logic             tick_full;
`ifdef PARITY_EN
  logic             perr_q, perr_d;
  logic             par_bad_q, par_bad_d;
`endif

  // State and datapath registers; the synchroniser resets to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b0;
      sync_vld_q <= 2'b00;
      cnt_q      <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PARITY_EN
      perr_q     <= 1'b0;
      par_bad_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      rx_prev_q  <= rx_prev_d;
      sync_vld_q <= sync_vld_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      a_q        <= a_d;
      b_q        <= b_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
`ifdef PARITY_EN
      perr_q     <= perr_d;
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  // Next-state, sampling and output logic.
  always_comb begin
    state_d    = state_q;
    rx_meta_d  = rx;
    rx_s_d     = rx_meta_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
    // rx_prev only goes high once a genuinely high line has passed the synchroniser,
    // so a line that is already low when reset releases cannot look like a start edge.
    rx_prev_d  = sync_vld_q[1] & rx_s_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    a_d        = a_q;
    b_d        = b_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
`ifdef PARITY_EN
    perr_d     = 1'b0;
    par_bad_d  = par_bad_q;
`endif
    tick_full  = (cnt_q == CNT_FULL);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) state_d = S_START;
      end
      S_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick_full) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick_full) begin
          cnt_d     = '0;
          par_bad_d = rx_s_q ^ (^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick_full) begin
          cnt_d = '0;
          // A low stop bit reports frame_err, which takes priority over a parity error.
          if (!rx_s_q) begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
`ifdef PARITY_EN
          end else if (par_bad_q) begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            a_d     = shift_q[3:0];
            b_d     = shift_q[7:4];
            valid_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign a              = a_q;
  assign b              = b_q;
  assign operands_valid = valid_q;
  assign frame_err      = ferr_q;
  assign busy           = busy_q;
`ifdef PARITY_EN
  assign parity_err     = perr_q;
`else
  assign parity_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_operand_rx.sv
// tb_uart_operand_rx: directed bench for uart_operand_rx with CLKS_PER_BIT = 16.
//   It drives UART frames bit by bit and compares the operands, the pulse counts and busy
//   against hand-computed values.
`timescale 1ns/1ps
module tb_uart_operand_rx;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [3:0] a, b;
  logic       operands_valid, frame_err, parity_err, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_perr  = 0;
  int n_multi = 0;
  logic busy_mid = 1'b0;

  always #5 clk = ~clk;

  uart_operand_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx             (rx),
    .a              (a),
    .b              (b),
    .operands_valid (operands_valid),
    .frame_err      (frame_err),
    .parity_err     (parity_err),
    .busy           (busy)
  );

  // Pulse counters; a pulse longer than one cycle shows up as an extra count.
  always @(negedge clk) begin
    if (rst_n) begin
      if (operands_valid) n_valid++;
      if (frame_err)      n_ferr++;
      if (parity_err)     n_perr++;
      if (int'(operands_valid) + int'(frame_err) + int'(parity_err) > 1) n_multi++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  // One frame: start bit, D0..D7 LSB first, optional parity bit, stop bit.
  // rx is left at the stop level when the task returns.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_ok);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (CPB / 2) @(posedge clk);
      if (i == 0) busy_mid = busy;
      repeat (CPB / 2) @(posedge clk);
    end
`ifdef PARITY_EN
    rx = par_ok ? (^data) : ~(^data);
    repeat (CPB) @(posedge clk);
`else
    if (!par_ok) $display("[TB] note: parity flip ignored in 8N1 build");
`endif
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, p0;
    logic [7:0] d9c;

    // Reset while the line is already low.
    rst_n = 1'b0;
    rx    = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_a", 32'(a), 32'h0);
    check("rst_b", 32'(b), 32'h0);
    check("rst_valid", 32'(operands_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("low_line_after_rst_busy", 32'(busy), 32'h0);
    idle(10);

    // Test 1: a single byte, 0x53.
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h53, 1'b1, 1'b1);
    check("t1_busy_mid", 32'(busy_mid), 32'h1);
    idle(4);
    @(negedge clk);
    check("t1_a", 32'(a), 32'h3);
    check("t1_b", 32'(b), 32'h5);
    check("t1_valid_pulses", 32'(n_valid - v0), 32'h1);
    check("t1_busy_after", 32'(busy), 32'h0);

    // Test 2: 0xFF followed by 0x00 with no idle gap.
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hFF, 1'b1, 1'b1);
    check("t2_ab_first", 32'({b, a}), 32'hFF);
    send_frame(8'h00, 1'b1, 1'b1);
    idle(4);
    @(negedge clk);
    check("t2_ab_second", 32'({b, a}), 32'h00);
    check("t2_valid_pulses", 32'(n_valid - v0), 32'h2);
    check("t2_ferr_pulses", 32'(n_ferr - f0), 32'h0);

    // Test 3: a 4-cycle glitch while idle.
    idle(10);
    v0 = n_valid;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("t3_busy_during", 32'(busy), 32'h1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("t3_busy_back", 32'(busy), 32'h0);
    check("t3_valid_pulses", 32'(n_valid - v0), 32'h0);
    check("t3_ab_hold", 32'({b, a}), 32'h00);

    // Test 4: 0xA7 with a low stop bit and the line held low for 40 clk, then 0x21.
    idle(10);
    send_frame(8'h11, 1'b1, 1'b1);
    idle(10);
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA7, 1'b0, 1'b1);
    repeat (40 - CPB) @(posedge clk);
    @(negedge clk);
    check("t4_ferr_pulses", 32'(n_ferr - f0), 32'h1);
    check("t4_busy_low_line", 32'(busy), 32'h1);
    check("t4_ab_hold", 32'({b, a}), 32'h11);
    check("t4_no_valid", 32'(n_valid - v0), 32'h0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t4_busy_released", 32'(busy), 32'h0);
    idle(10);
    send_frame(8'h21, 1'b1, 1'b1);
    idle(4);
    @(negedge clk);
    check("t4_next_a", 32'(a), 32'h1);
    check("t4_next_b", 32'(b), 32'h2);
    check("t4_next_valid", 32'(n_valid - v0), 32'h1);

    // Test 5: reset during D4 of 0x9C, then 0x12.
    idle(10);
    v0 = n_valid;
    d9c = 8'h9C;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d9c[i];
      repeat (CPB) @(posedge clk);
    end
    rx = d9c[4];
    repeat (CPB / 2) @(posedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_busy_in_rst", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle(20);
    @(negedge clk);
    check("t5_ab_after_rst", 32'({b, a}), 32'h00);
    check("t5_busy_after_rst", 32'(busy), 32'h0);
    send_frame(8'h12, 1'b1, 1'b1);
    idle(4);
    @(negedge clk);
    check("t5_a", 32'(a), 32'h2);
    check("t5_b", 32'(b), 32'h1);
    check("t5_valid_total", 32'(n_valid - v0), 32'h1);

    // Test 6: parity handling.
    idle(10);
    v0 = n_valid; p0 = n_perr;
`ifdef PARITY_EN
    send_frame(8'h53, 1'b1, 1'b0);
    idle(4);
    @(negedge clk);
    check("t6_perr_pulses", 32'(n_perr - p0), 32'h1);
    check("t6_ab_hold", 32'({b, a}), 32'h12);
    check("t6_no_valid", 32'(n_valid - v0), 32'h0);
    send_frame(8'h53, 1'b1, 1'b1);
    idle(4);
    @(negedge clk);
    check("t6_good_ab", 32'({b, a}), 32'h53);
    check("t6_good_valid", 32'(n_valid - v0), 32'h1);
    check("t6_good_perr", 32'(n_perr - p0), 32'h1);
`else
    send_frame(8'h53, 1'b1, 1'b1);
    idle(4);
    @(negedge clk);
    check("t6_ab", 32'({b, a}), 32'h53);
    check("t6_perr_tied", 32'(n_perr), 32'h0);
`endif

    check("pulses_exclusive", 32'(n_multi), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
